// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer and its tick divider.
package traffic_pkg;

   typedef enum logic [2:0] {
      MAIN_G   = 3'd0,
      MAIN_Y   = 3'd1,
      WALK     = 3'd2,
      SIDE_G   = 3'd3,
      SIDE_EXT = 3'd4,
      SIDE_Y   = 3'd5
   } state_t;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam int DEF_T_BASE = 6;
   localparam int DEF_T_EXT  = 3;
   localparam int DEF_T_YEL  = 2;
   localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/traffic_sequencer_if.sv
// Tick/sensor/walk inputs and lamp outputs of the traffic sequencer.
interface traffic_sequencer_if;
   logic       Tick;
   logic       Sensor;
   logic       Walk_Req;
   logic [2:0] Main_RYG;
   logic [2:0] Side_RYG;
   logic       Walk_Lamp;
   logic       Walk_Pending;

   modport master (
      output Tick, Sensor, Walk_Req,
      input  Main_RYG, Side_RYG, Walk_Lamp, Walk_Pending
   );

   modport slave (
      input  Tick, Sensor, Walk_Req,
      output Main_RYG, Side_RYG, Walk_Lamp, Walk_Pending
   );
endinterface

// File: rtl/walk_latch.sv
// Pedestrian request latch: sync active-low reset, gated set, clear wins over set.
module walk_latch (
   input  logic clk,
   input  logic Reset_n,
   input  logic set,
   input  logic set_en,
   input  logic clr,
   output logic q
);
   logic pending_q, pending_d;

   always_comb begin
      pending_d = pending_q;
      if (set && set_en) pending_d = 1'b1;
      if (clr)           pending_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!Reset_n) pending_q <= 1'b0;
      else          pending_q <= pending_d;
   end

   assign q = pending_q;
endmodule

// File: rtl/traffic_sequencer.sv
// Main/side-street light sequencer; phases are timed in Tick pulses.
//
// state    | meaning
// MAIN_G   | main green, side red, 2*T_BASE ticks
// MAIN_Y   | main yellow, side red, T_YEL ticks
// WALK     | all red, walk lamp on, T_EXT ticks
// SIDE_G   | side green, main red, T_BASE ticks
// SIDE_EXT | side green extension when a vehicle waits, T_EXT ticks
// SIDE_Y   | side yellow, main red, T_YEL ticks
module traffic_sequencer
   import traffic_pkg::*;
#(
   parameter int T_BASE = DEF_T_BASE,
   parameter int T_EXT  = DEF_T_EXT,
   parameter int T_YEL  = DEF_T_YEL,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                Reset_n,
   traffic_sequencer_if.slave  bus
);
   localparam logic [CNT_W-1:0] LAST_MAIN_G = CNT_W'(2*T_BASE - 1);
   localparam logic [CNT_W-1:0] LAST_SIDE_G = CNT_W'(T_BASE - 1);
   localparam logic [CNT_W-1:0] LAST_EXT    = CNT_W'(T_EXT - 1);
   localparam logic [CNT_W-1:0] LAST_YEL    = CNT_W'(T_YEL - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_last;
   logic             expire;
   logic             walk_pending;
   logic             walk_clr;
   logic [2:0]       main_ryg, side_ryg;
   logic             walk_lamp;

   always_comb begin
      cnt_last = LAST_MAIN_G;
      case (state_q)
         MAIN_G:   cnt_last = LAST_MAIN_G;
         MAIN_Y:   cnt_last = LAST_YEL;
         WALK:     cnt_last = LAST_EXT;
         SIDE_G:   cnt_last = LAST_SIDE_G;
         SIDE_EXT: cnt_last = LAST_EXT;
         SIDE_Y:   cnt_last = LAST_YEL;
         default:  cnt_last = LAST_MAIN_G;
      endcase
   end

   assign expire = bus.Tick && (cnt_q == cnt_last);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      walk_clr = 1'b0;
      if (expire) begin
         cnt_d = '0;
         case (state_q)
            MAIN_G: state_d = MAIN_Y;
            MAIN_Y: begin
               if (walk_pending) begin
                  state_d  = WALK;
                  walk_clr = 1'b1;
               end else begin
                  state_d = SIDE_G;
               end
            end
            WALK:     state_d = SIDE_G;
            SIDE_G:   state_d = bus.Sensor ? SIDE_EXT : SIDE_Y;
            SIDE_EXT: state_d = SIDE_Y;
            SIDE_Y:   state_d = MAIN_G;
            default:  state_d = MAIN_G;
         endcase
      end else if (bus.Tick) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         state_q <= MAIN_G;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Requests arriving while the walk phase is already running are not for a later cycle.
   walk_latch u_walk_latch (
      .clk     (clk),
      .Reset_n (Reset_n),
      .set     (bus.Walk_Req),
      .set_en  (state_q != WALK),
      .clr     (walk_clr),
      .q       (walk_pending)
   );

   always_comb begin
      main_ryg  = LAMP_R;
      side_ryg  = LAMP_R;
      walk_lamp = 1'b0;
      case (state_q)
         MAIN_G:   main_ryg = LAMP_G;
         MAIN_Y:   main_ryg = LAMP_Y;
         WALK:     walk_lamp = 1'b1;
         SIDE_G:   side_ryg = LAMP_G;
         SIDE_EXT: side_ryg = LAMP_G;
         SIDE_Y:   side_ryg = LAMP_Y;
         default:  main_ryg = LAMP_R;
      endcase
   end

   assign bus.Main_RYG     = main_ryg;
   assign bus.Side_RYG     = side_ryg;
   assign bus.Walk_Lamp    = walk_lamp;
   assign bus.Walk_Pending = walk_pending;
endmodule
